fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the single write port of the sync FIFO among NUM_REQ requesters. Each requester drives a valid/ready/data/last stream. The arbiter grants one requester at a time for a burst, passes its stream through to the FIFO write handshake, and releases the grant at end-of-packet or after MAX_BURST words. It sits between the requesters and the FIFO write side (FIFO i_valid_s / o_ready_s / o_almostfull).

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, FIFO word width
MAX_BURST, 4, max words transferred per grant before forced release (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active low
i_valid  in  NUM_REQ  per-requester word valid
i_data  in  NUM_REQ*DATA_WIDTH  per-requester data; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
i_last  in  NUM_REQ  per-requester end-of-packet marker, qualified by i_valid
o_ready  out  NUM_REQ  per-requester accept
o_valid_s  out  1  write request to FIFO
o_data_s  out  DATA_WIDTH  write data to FIFO
i_ready_s  in  1  FIFO not full (FIFO o_ready_s)
i_almostfull  in  1  FIFO almost-full flag
o_grant  out  NUM_REQ  one-hot current grant, 0 when idle
o_busy  out  1  high while a grant is held

Behaviour:
- Reset: asynchronous on reset_n low.
  - State IDLE; o_grant=0, o_busy=0, o_valid_s=0, o_ready=0, burst count=0.
  - Priority pointer = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, GRANT.
- IDLE:
  - o_valid_s=0; o_ready all 0; o_data_s is don't-care (driven 0).
  - If any i_valid is high and i_almostfull=0, select the first requester with i_valid high, searching from pointer+1 upward with wrap-around.
  - Register the selection into o_grant, go to GRANT, clear burst count.
  - Grant latency is 1 cycle after i_valid is sampled.
  - If i_almostfull=1, no grant is issued and the arbiter stays in IDLE.
  - i_ready_s is not used for grant decisions.
- GRANT (g = granted index):
  - Combinational pass-through: o_valid_s=i_valid[g], o_data_s=i_data[g], o_ready[g]=i_ready_s; all other o_ready bits are 0.
  - Transfer = o_valid_s & i_ready_s.
  - Each transfer increments the burst count.
  - Release on a transfer with i_last[g]=1, or on a transfer where count+1==MAX_BURST. On release:
    - next state IDLE, o_grant=0, pointer=g, count=0.
  - Grant is held while i_valid[g]=0; there is no timeout.
  - i_almostfull is ignored during GRANT; FIFO-full backpressure comes only through i_ready_s.
  - i_ready_s=0 stalls the transfer: count holds and the requester must hold its data.
- Bubble: exactly one idle cycle (o_valid_s=0) between consecutive grants.
- Count width is $clog2(MAX_BURST+1). With MAX_BURST=1, every transfer releases.
- A packet longer than MAX_BURST is split across grants. The remainder competes again in round-robin, and its i_last is honoured when it eventually arrives.
- o_busy = (state==GRANT).
- Simultaneous i_valid changes on non-granted requesters while in GRANT have no effect.
- Reset mid-burst:
  - All outputs go to their reset values immediately.
  - A partially transferred packet is abandoned; no recovery state is kept.

Test Plan:
1. Req0 sends 3 words A1,A2,A3 (i_last on A3), i_ready_s=1 → o_grant=0001 one cycle after i_valid[0]; A1..A3 written on 3 consecutive cycles; o_grant=0 and o_busy=0 the cycle after A3.
2. All 4 requesters continuously send single-word packets (i_last=1) → grant order 0,1,2,3,0,1…; one o_valid_s=0 bubble between grants; 4 words per 8 cycles.
3. MAX_BURST=4: req1 sends a 6-word packet (last on word 6) while req2 waits with a 1-word packet → words 1–4 from req1, then req2's word, then req1 words 5–6; grant released after word 6.
4. i_ready_s driven 0 for 3 cycles after the 2nd word of a burst → o_ready[g]=0, o_valid_s stays 1, o_data_s stable, burst count stays 2; resumes when i_ready_s returns to 1.
5. i_almostfull=1 with i_valid=0110 in IDLE → o_grant stays 0 for the whole interval. Deassert i_almostfull → o_grant=0010 on the next cycle.
6. reset_n pulled low in the middle of the 2nd word of a burst from req2 → o_grant, o_ready and o_valid_s go to 0 with no clock edge. After reset release with i_valid=1111, first grant=0001.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready/last streams.
// A grant covers one burst, which ends at end-of-packet or after MAX_BURST words.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_REQ-1:0]            i_last,
  output logic [NUM_REQ-1:0]            o_ready,
  output logic                          o_valid_s,
  output logic [DATA_WIDTH-1:0]         o_data_s,
  input  logic                          i_ready_s,
  input  logic                          i_almostfull,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0]   PTR_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   sel_idx_s;
  logic               sel_found_s;
  logic               xfer_s;
  logic               release_s;

  // Round-robin pick: first valid requester after the pointer, with wrap-around.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sel_idx_s   = (!sel_found_s && i_valid[(int'(ptr_q) + i) % NUM_REQ])
                    ? IDX_W'((int'(ptr_q) + i) % NUM_REQ) : sel_idx_s;
      sel_found_s = sel_found_s | i_valid[(int'(ptr_q) + i) % NUM_REQ];
    end
  end

  assign xfer_s    = (state_q == ST_GRANT) & i_valid[gidx_q] & i_ready_s;
  assign release_s = xfer_s & (i_last[gidx_q] | ((cnt_q + CNT_ONE) == CNT_MAX));

  // Next-state logic plus the combinational pass-through of the granted stream.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    o_valid_s = 1'b0;
    o_data_s  = '0;
    o_ready   = '0;
    case (state_q)
      ST_IDLE: begin
        // Almost-full only gates new grants; i_ready_s is not consulted here.
        if (sel_found_s && !i_almostfull) begin
          state_d = ST_GRANT;
          grant_d = ONE_HOT0 << sel_idx_s;
          gidx_d  = sel_idx_s;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_GRANT: begin
        o_valid_s       = i_valid[gidx_q];
        o_data_s        = i_data[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
        o_ready[gidx_q] = i_ready_s;
        if (release_s) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = gidx_q;
          cnt_d   = '0;
        end else if (xfer_s) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset leaves the pointer at the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after it.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  i_valid;
  logic [31:0] i_data;
  logic [3:0]  i_last;
  logic [3:0]  o_ready;
  logic        o_valid_s;
  logic [7:0]  o_data_s;
  logic        i_ready_s;
  logic        i_almostfull;
  logic [3:0]  o_grant;
  logic        o_busy;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_valid_s    (o_valid_s),
    .o_data_s     (o_data_s),
    .i_ready_s    (i_ready_s),
    .i_almostfull (i_almostfull),
    .o_grant      (o_grant),
    .o_busy       (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to 1 ns after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, {28'd0, o_grant}, 32'h0);
    chk({tag, "_busy"},  {31'd0, o_busy}, 32'h0);
    chk({tag, "_valid"}, {31'd0, o_valid_s}, 32'h0);
    chk({tag, "_ready"}, {28'd0, o_ready}, 32'h0);
  endtask

  task automatic chk_word(input string tag, input logic [3:0] g, input logic [7:0] d);
    chk({tag, "_grant"}, {28'd0, o_grant}, {28'd0, g});
    chk({tag, "_valid"}, {31'd0, o_valid_s}, 32'h1);
    chk({tag, "_data"},  {24'd0, o_data_s}, {24'd0, d});
  endtask

  initial begin : stim
    logic [1:0] rr_order [5];
    rr_order = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    reset_n = 1'b0; i_valid = 4'h0; i_data = 32'h0; i_last = 4'h0;
    i_ready_s = 1'b1; i_almostfull = 1'b0;
    #2;
    chk_idle("rst");
    #10 reset_n = 1'b1;

    // 1: req0 sends A1..A3 with last on A3
    cyc();
    i_valid = 4'b0001; i_data[7:0] = 8'hA1;
    #1 chk("t1_pre_grant", {28'd0, o_grant}, 32'h0);
    cyc(); #1 chk_word("t1_w1", 4'b0001, 8'hA1);
    chk("t1_ready", {28'd0, o_ready}, 32'h1);
    cyc(); i_data[7:0] = 8'hA2;
    #1 chk_word("t1_w2", 4'b0001, 8'hA2);
    cyc(); i_data[7:0] = 8'hA3; i_last = 4'b0001;
    #1 chk_word("t1_w3", 4'b0001, 8'hA3);
    cyc(); i_valid = 4'h0; i_last = 4'h0;
    #1 chk_idle("t1_end");

    // 2: all four send single-word packets; pointer is now 0 so order starts at 1
    cyc();
    i_valid = 4'b1111; i_last = 4'b1111; i_data = 32'h13121110;
    #1 chk("t2_pre_valid", {31'd0, o_valid_s}, 32'h0);
    for (int j = 0; j < 5; j++) begin
      cyc(); #1
      chk_word($sformatf("t2_g%0d", j), 4'b0001 << rr_order[j], 8'h10 + {6'd0, rr_order[j]});
      cyc(); #1
      chk($sformatf("t2_bubble%0d", j), {31'd0, o_valid_s}, 32'h0);
      chk($sformatf("t2_bgrant%0d", j), {28'd0, o_grant}, 32'h0);
    end
    i_valid = 4'h0; i_last = 4'h0;

    // reset so req1 wins ahead of req2 in the split-packet test
    cyc();
    reset_n = 1'b0;
    #1 chk_idle("rst2");
    reset_n = 1'b1;

    // 3: req1 6-word packet split by MAX_BURST, req2 single word in between
    i_valid = 4'b0110; i_last = 4'b0100; i_data = 32'h00_2A_31_00;
    cyc(); #1 chk_word("t3_w1", 4'b0010, 8'h31);
    cyc(); i_data[15:8] = 8'h32; #1 chk_word("t3_w2", 4'b0010, 8'h32);
    cyc(); i_data[15:8] = 8'h33; #1 chk_word("t3_w3", 4'b0010, 8'h33);
    cyc(); i_data[15:8] = 8'h34; #1 chk_word("t3_w4", 4'b0010, 8'h34);
    cyc(); i_data[15:8] = 8'h35;
    #1 chk_idle("t3_split");
    cyc(); #1 chk_word("t3_r2", 4'b0100, 8'h2A);
    chk("t3_r2_ready", {28'd0, o_ready}, 32'h4);
    cyc(); i_valid = 4'b0010; i_last = 4'b0000;
    #1 chk("t3_bubble2", {31'd0, o_valid_s}, 32'h0);
    cyc(); #1 chk_word("t3_w5", 4'b0010, 8'h35);
    cyc(); i_data[15:8] = 8'h36; i_last = 4'b0010;
    #1 chk_word("t3_w6", 4'b0010, 8'h36);
    cyc(); i_valid = 4'h0; i_last = 4'h0;
    #1 chk_idle("t3_end");

    // 4: stall for 3 cycles after the 2nd word; release must still come after word 4
    i_valid = 4'b1000; i_data = 32'h41_00_00_00;
    cyc(); #1 chk_word("t4_w1", 4'b1000, 8'h41);
    cyc(); i_data[31:24] = 8'h42;
    cyc(); i_data[31:24] = 8'h43; i_ready_s = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1 chk_word($sformatf("t4_stall%0d", j), 4'b1000, 8'h43);
      chk($sformatf("t4_stall_rdy%0d", j), {28'd0, o_ready}, 32'h0);
      cyc();
    end
    i_ready_s = 1'b1;
    #1 chk("t4_resume_rdy", {28'd0, o_ready}, 32'h8);
    cyc(); i_data[31:24] = 8'h44;
    #1 chk_word("t4_w4", 4'b1000, 8'h44);
    cyc(); i_valid = 4'h0;
    #1 chk_idle("t4_end");

    // 5: almost-full blocks grants in IDLE but is ignored once granted
    i_almostfull = 1'b1; i_valid = 4'b0110; i_last = 4'b0010; i_data = 32'h00_00_51_00;
    for (int j = 0; j < 3; j++) begin
      cyc(); #1 chk($sformatf("t5_af%0d", j), {28'd0, o_grant}, 32'h0);
    end
    i_almostfull = 1'b0;
    cyc(); i_almostfull = 1'b1;
    #1 chk_word("t5_grant", 4'b0010, 8'h51);
    chk("t5_af_ready", {28'd0, o_ready}, 32'h2);
    cyc(); i_valid = 4'h0; i_last = 4'h0; i_almostfull = 1'b0;
    #1 chk_idle("t5_end");

    // 6: asynchronous reset during req2's 2nd word
    i_valid = 4'b0100; i_data = 32'h00_61_00_00;
    cyc(); #1 chk_word("t6_w1", 4'b0100, 8'h61);
    cyc(); i_data[23:16] = 8'h62;
    #1 chk_word("t6_w2", 4'b0100, 8'h62);
    #1 reset_n = 1'b0;
    #1 chk_idle("t6_async");
    i_valid = 4'b1111;
    #1 reset_n = 1'b1;
    cyc(); #1 chk("t6_first_grant", {28'd0, o_grant}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
